// File: rtl/ulut_array.sv
// Array of CH independent K-input LUT channels, configured through a serial shift chain.
// Define ULUT_CHAIN_OUT_EN to add cfg_sout and enable daisy-chained loading across instances.
module ulut_array #(
    parameter int K  = 2,
    parameter int CH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    input  logic              cfg_data,
    output logic              cfg_done,
    input  logic [CH*K-1:0]   lut_in,
    output logic [CH-1:0]     lut_out
`ifdef ULUT_CHAIN_OUT_EN
    ,
    output logic              cfg_sout
`endif
);

    localparam int TT    = 1 << K;
    localparam int FW    = TT + 1;
    localparam int TOTAL = CH * FW;
    localparam int CW    = $clog2(TOTAL + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(TOTAL - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(TOTAL);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [TOTAL-1:0]  chain;
    logic [CW-1:0]     cnt;
    logic [CH-1:0]     out_q;
    logic [CH-1:0]     tt_val;
    logic              shift_en;
    logic              cnt_clr;
    logic              running;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A start pulse always wins over a simultaneous data bit and restarts the count.
    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        cnt_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    next_state = LOAD;
                    cnt_clr    = 1'b1;
                end
            end
            LOAD: begin
                if (cfg_start) begin
                    cnt_clr = 1'b1;
                end else if (cfg_valid) begin
                    shift_en = 1'b1;
`ifndef ULUT_CHAIN_OUT_EN
                    if (cnt == CNT_LAST) begin
                        next_state = RUN;
                    end
`endif
                end
`ifdef ULUT_CHAIN_OUT_EN
                else if (cnt == CNT_FULL) begin
                    next_state = RUN;
                end
`endif
            end
            RUN: begin
                if (cfg_start) begin
                    next_state = LOAD;
                    cnt_clr    = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            cnt   <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (shift_en) begin
            chain <= {chain[TOTAL-2:0], cfg_data};
`ifdef ULUT_CHAIN_OUT_EN
            if (cnt != CNT_FULL) begin
                cnt <= cnt + CW'(1);
            end
`else
            cnt <= cnt + CW'(1);
`endif
        end
    end

    assign running = (state == RUN);

`ifdef ULUT_CHAIN_OUT_EN
    assign cfg_done = running || ((state == LOAD) && (cnt == CNT_FULL));
    assign cfg_sout = chain[TOTAL-1];
`else
    assign cfg_done = running;
`endif

    // Registered channels only track the table while running, so they read 0 on the first RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else if (running) begin
            out_q <= tt_val;
        end else begin
            out_q <= '0;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [TT-1:0] tt;
        logic          reg_sel;

        assign tt         = chain[c*FW +: TT];
        assign reg_sel    = chain[c*FW + TT];
        assign tt_val[c]  = tt[lut_in[c*K +: K]];
        assign lut_out[c] = running & (reg_sel ? out_q[c] : tt_val[c]);
    end

endmodule

// File: tb/tb_ulut_array.sv
// Self-checking bench for ulut_array (K=2, CH=2) against a bit-list reference model.
module tb_ulut_array;

    localparam int K     = 2;
    localparam int CH    = 2;
    localparam int TT    = 1 << K;
    localparam int FW    = TT + 1;
    localparam int TOTAL = CH * FW;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_start;
    logic              cfg_valid;
    logic              cfg_data;
    logic              cfg_done;
    logic [CH*K-1:0]   lut_in;
    logic [CH-1:0]     lut_out;
`ifdef ULUT_CHAIN_OUT_EN
    logic              cfg_sout;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: the accepted configuration bits and the run/load status.
    bit                m_loading;
    bit                m_running;
    int                m_cnt;
    logic [TOTAL-1:0]  m_chain;
    logic [CH-1:0]     m_regq;

    logic [CH-1:0]     obs_out;
    logic              obs_done;

    ulut_array #(.K(K), .CH(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_done  (cfg_done),
        .lut_in    (lut_in),
        .lut_out   (lut_out)
`ifdef ULUT_CHAIN_OUT_EN
        ,
        .cfg_sout  (cfg_sout)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic tableBit(input int c, input logic [K-1:0] sel);
        return m_chain[c*FW + int'(sel)];
    endfunction

    // One clock cycle: drive, check outputs mid-cycle, then advance the model at the edge.
    task automatic applyStimulus(input logic r, input logic s, input logic v, input logic d,
                                 input logic [CH*K-1:0] li, input string tag);
        logic [CH-1:0] exp_out;
        logic [CH-1:0] next_regq;
        rst       = r;
        cfg_start = s;
        cfg_valid = v;
        cfg_data  = d;
        lut_in    = li;
        @(negedge clk);
        exp_out = '0;
        for (int c = 0; c < CH; c++) begin
            if (m_running) begin
                if (m_chain[c*FW + TT]) exp_out[c] = m_regq[c];
                else                    exp_out[c] = tableBit(c, li[c*K +: K]);
            end
        end
        obs_out  = lut_out;
        obs_done = cfg_done;
        checkOutput({tag, "_done"}, 32'(cfg_done), 32'(m_running));
        checkOutput({tag, "_out"}, 32'(lut_out), 32'(exp_out));
        @(posedge clk);
        if (r) begin
            m_loading = 0;
            m_running = 0;
            m_cnt     = 0;
            m_chain   = '0;
            m_regq    = '0;
        end else begin
            next_regq = '0;
            for (int c = 0; c < CH; c++) begin
                if (m_running) next_regq[c] = tableBit(c, li[c*K +: K]);
            end
            m_regq = next_regq;
            if (s) begin
                m_loading = 1;
                m_running = 0;
                m_cnt     = 0;
            end else if (m_loading && v) begin
                m_chain = {m_chain[TOTAL-2:0], d};
                m_cnt++;
                if (m_cnt == TOTAL) begin
                    m_loading = 0;
                    m_running = 1;
                end
            end
        end
        #1;
    endtask

    task automatic loadChain(input logic [TOTAL-1:0] bits, input int gap_pct, input string tag);
        applyStimulus(0, 1, 0, 0, '0, {tag, "_start"});
        for (int i = TOTAL - 1; i >= 0; i--) begin
            while (int'($urandom_range(0, 99)) < gap_pct) begin
                applyStimulus(0, 0, 0, 1'($urandom_range(0, 1)), '0, {tag, "_gap"});
            end
            applyStimulus(0, 0, 1, bits[i], '0, {tag, "_shift"});
        end
    endtask

    // Chain 10'h306: channel 0 is combinational XOR, channel 1 is registered AND.
    task automatic sweepXorAnd(input string tag);
        logic [3:0] v;
        logic       prev_and;
        prev_and = 1'b0;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            applyStimulus(0, 0, 0, 0, v, tag);
            checkOutput({tag, "_xor"}, 32'(obs_out[0]), 32'(v[0] ^ v[1]));
            checkOutput({tag, "_andreg"}, 32'(obs_out[1]), 32'(prev_and));
            checkOutput({tag, "_doneup"}, 32'(obs_done), 32'd1);
            prev_and = v[2] & v[3];
        end
    endtask

    initial begin
        rst       = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = 1'b0;
        lut_in    = '0;
        m_loading = 0;
        m_running = 0;
        m_cnt     = 0;
        m_chain   = '0;
        m_regq    = '0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1, 0, 0, 0, 4'hF, "reset");
        checkOutput("reset_done_low", 32'(obs_done), 32'd0);

        // Basic load and sweep.
        loadChain(10'h306, 0, "load306");
        sweepXorAnd("sweep306");

        // Reset in the middle of a reload, then reload from scratch.
        applyStimulus(0, 1, 0, 0, '0, "mid_start");
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1'(i), '0, "mid_shift");
        applyStimulus(1, 0, 0, 0, 4'hF, "mid_rst0");
        applyStimulus(1, 0, 0, 0, 4'hF, "mid_rst1");
        applyStimulus(0, 0, 1, 1, 4'hF, "post_rst");
        checkOutput("post_rst_done", 32'(obs_done), 32'd0);
        checkOutput("post_rst_out", 32'(obs_out), 32'd0);
        loadChain(10'h306, 0, "reload306");
        sweepXorAnd("resweep306");

        // Gaps between bits, then extra valid pulses once complete.
        loadChain(10'h306, 40, "gap306");
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1'($urandom_range(0, 1)), '0, "extra");
        sweepXorAnd("gapsweep");

        // Start collides with the 6th data bit; a full zero load must follow.
        applyStimulus(0, 1, 0, 0, '0, "rs_start");
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 1, '0, "rs_shift");
        applyStimulus(0, 1, 1, 1, '0, "rs_collide");
        for (int i = 0; i < TOTAL; i++) applyStimulus(0, 0, 1, 0, '0, "rs_zero");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 0, 0, 4'(i), "zero_sweep");
            checkOutput("zero_sweep_val", 32'(obs_out), 32'd0);
        end

        // Random configurations exercised with random inputs.
        for (int t = 0; t < 6; t++) begin
            loadChain(10'($urandom), 25, "rand_load");
            for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1'($urandom_range(0, 1)),
                                                       1'($urandom_range(0, 1)), 4'($urandom), "rand_run");
        end

        // Fully random control traffic including restarts, collisions and resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 4),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), "chaos");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ulut_array.md
Name: ulut_array

Overview:
- Parametrised successor to the fixed-function universal 2-input gate cell.
- Holds CH independent K-input LUT channels. Each channel has its own output-register select.
- Configuration is loaded serially through a counted shift chain under a small load FSM.
- Sits between the user-project I/O fabric and the gate-cell mesh, providing reconfigurable, optionally registered logic.

Parameters:
- K, 2, inputs per LUT channel (1..4); truth table is 2^K bits.
- CH, 4, number of independent LUT channels (1..16).
- FW, derived, 2^K+1, configuration field bits per channel (truth table plus register-select bit).
- TOTAL, derived, CH*FW, total configuration chain length.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_start  in  1  one-cycle pulse; begins a new configuration load
- cfg_valid  in  1  qualifies cfg_data for one shift
- cfg_data  in  1  serial configuration bit, MSB of chain first
- cfg_done  out  1  high while in RUN (configuration complete and active)
- lut_in  in  CH*K  channel c uses lut_in[c*K +: K]
- lut_out  out  CH  channel c result

Behaviour:
- Reset:
  - Synchronous, active-high.
  - State goes to IDLE; config chain, bit counter and all output registers clear to 0.
  - cfg_done=0, lut_out=0.
- FSM states are IDLE, LOAD, RUN.
- IDLE:
  - lut_out=0; cfg_valid ignored.
  - cfg_start -> LOAD, with the counter cleared.
- LOAD:
  - Each cycle with cfg_valid=1: chain <= {chain[TOTAL-2:0], cfg_data}; counter increments.
  - When the shift that brings the counter to TOTAL occurs, the next state is RUN.
  - lut_out=0 and cfg_done=0 throughout LOAD. Channel output registers are held at 0.
- RUN:
  - cfg_done=1.
  - cfg_valid ignored; the chain is frozen.
  - cfg_start -> LOAD: cfg_done drops the next cycle and the chain contents are retained until overwritten by shifting.
- Field layout: channel c occupies chain[c*FW +: FW].
  - Bits [2^K-1:0] are the truth table: entry i is the output for input value i.
  - Bit [2^K] = REG.
- Channel output:
  - REG=0: lut_out[c] = tt[lut_in slice], combinational, zero latency.
  - REG=1: lut_out[c] = flop loaded with tt[lut_in slice] on every RUN cycle, 1-cycle latency. The flop reads 0 on the first RUN cycle.
- Simultaneous events:
  - cfg_start with cfg_valid in the same cycle: start wins, the data bit is discarded, and the counter is 0.
  - cfg_start in LOAD restarts the load (counter cleared).
  - rst overrides everything.
- Counter width is clog2(TOTAL+1). It never wraps, because the FSM leaves LOAD at TOTAL.
- Extra cfg_valid pulses after completion have no effect.

Optional Feature:
- Macro: ULUT_CHAIN_OUT_EN.
- When defined:
  - Adds output port cfg_sout (1 bit) = chain[TOTAL-1], registered as part of the chain.
  - Multiple ulut_array instances can then be daisy-chained. cfg_sout of one feeds cfg_data of the next, with a shared cfg_valid.
  - In this mode LOAD does not terminate at TOTAL. The counter saturates at TOTAL and cfg_done rises then.
  - Shifting continues while cfg_valid=1 until cfg_start or rst.
  - lut_out stays gated to 0 until cfg_valid has been low for one cycle with counter==TOTAL; only then does the FSM enter RUN.
- When undefined: no cfg_sout port; behaviour is exactly as above.

Test Plan:
- Reset: assert rst for 2 cycles mid-LOAD -> cfg_done=0, lut_out=0; the next cfg_start load starts from counter 0.
- K=2, CH=2 load: shift 1,1,0,0,0,0,0,1,1,0 (chain=10'h306; ch0 XOR comb, ch1 AND reg) -> cfg_done=1 the cycle after the 10th shift.
- RUN sweep: apply lut_in = {b1,a1,b0,a0} over all 16 values ->
  - lut_out[0] = a0^b0 in the same cycle.
  - lut_out[1] = a1&b1 of the previous cycle.
  - lut_out[1]=0 on the first RUN cycle.
- Load gaps: insert cfg_valid=0 gaps between bits, and add extra cfg_valid pulses after completion -> same final chain 10'h306; later pulses ignored.
- Restart: cfg_start in the same cycle as cfg_valid at bit 5 -> bit dropped, counter 0. A full 10-bit reload of all zeros then gives lut_out=2'b00 for all inputs.
- ULUT_CHAIN_OUT_EN: two instances chained with 20 shifts -> the first instance holds the last 10 bits shifted, the second holds the first 10. cfg_sout echoes data 10 cycles late.
